dcpu16_mbus_arb: RTL and testbench
==================================

// Module: dcpu16_mbus_arb
// PURPOSE
//  Shares one single-port Wishbone-style memory between the two DCPU16 buses: f (fetch) and g (data).
//  Sits between dcpu16_cpu and a single-port RAM, replacing the dual-port SRAM where only one port exists.
//  One grant at a time; a watchdog converts an unanswered access into an error-terminated cycle.
// PARAMETERS
//  AW   16  address width, all ports
//  DW   16  data width, all ports
//  TMO  15  watchdog limit: cycles in a grant state without m_ack before error termination (1..255)
// PORTS
//  clk    in   1   clock, all logic on rising edge
//  rst    in   1   asynchronous, active-high reset
//  f_adr  in   AW  fetch address
//  f_stb  in   1   fetch request; held high until f_ack or f_err
//  f_wre  in   1   fetch write enable
//  f_dto  in   DW  fetch write data
//  f_dti  out  DW  fetch read data; equals m_dti
//  f_ack  out  1   fetch cycle complete
//  f_err  out  1   fetch cycle timed out
//  g_adr  in   AW  data-bus address
//  g_stb  in   1   data-bus request
//  g_wre  in   1   data-bus write enable
//  g_dto  in   DW  data-bus write data
//  g_dti  out  DW  data-bus read data; equals m_dti
//  g_ack  out  1   data-bus cycle complete
//  g_err  out  1   data-bus cycle timed out
//  m_adr  out  AW  memory address
//  m_stb  out  1   memory strobe
//  m_wre  out  1   memory write enable
//  m_dto  out  DW  memory write data
//  m_dti  in   DW  memory read data
//  m_ack  in   1   memory acknowledge
// BEHAVIOUR
//  - States: IDLE, GNT_F, GNT_G. The state register is reset asynchronously to IDLE.
//  - IDLE: if any request is pending, move to a grant state at the next edge.
//    - Both requesting: the arbitration policy chooses (see CONFIGURATION).
//    - Otherwise the sole requester wins.
//  - Grant state:
//    - m_adr, m_wre, m_dto and m_stb are multiplexed combinationally from the granted port.
//    - m_stb equals the granted port's stb; it is 0 in IDLE.
//    - With no grant, m_adr, m_wre and m_dto are 0.
//  - Read data: f_dti = g_dti = m_dti at all times.
//  - Acknowledge: x_ack = m_ack & (state == GNT_x), combinational and the same cycle as m_ack.
//    - The state returns to IDLE at that edge.
//  - Turnaround: exactly one IDLE cycle between consecutive grants.
//    - Minimum latency, stb rising to m_stb: 1 cycle.
//  - Watchdog:
//    - wdt counts cycles spent in a grant state; it clears on entry to IDLE.
//    - When wdt == TMO and m_ack == 0, x_err pulses for 1 cycle and the state goes to IDLE.
//    - m_ack in the same cycle as expiry: the ack wins and no error is raised.
//  - Granted stb dropped before ack (protocol violation): return to IDLE at the next edge, no ack.
//  - Reset mid-cycle:
//    - m_stb falls immediately, with no wait for a clock edge.
//    - All acks and errors are 0; wdt = 0; the round-robin pointer takes its reset value.
//  - x_ack and x_err are never asserted together, and never for the non-granted port.
// CONFIGURATION
//  Macro DCPU16_ARB_RR_EN:
//  - Defined: round-robin. A 1-bit pointer last_g is set on a g grant and cleared on an f grant.
//    - Reset value of last_g: 1, so f wins first.
//    - On contention, the port not served last wins.
//  - Undefined: fixed priority; g always wins contention.
//    - f may starve under continuous g traffic; this is accepted.
// STRUCTURE
//  - Package dcpu16_arb_pkg holds:
//    - state encoding localparams ST_IDLE=2'd0, ST_GNT_F=2'd1, ST_GNT_G=2'd2
//    - the default TMO
//    - the watchdog width constant WDT_W=8
//  - Sub-module dcpu16_arb_wdt: a clear/enable counter with an expiry output.
//    - Ports: clk, rst, clr, en, exp.
//  - Top level: the FSM, the policy logic and the output muxes.
// TESTING
//  - Reset: hold rst; drive f_stb=g_stb=1.
//    -> m_stb=0, acks=0, errs=0; after release, the first grant follows 1 cycle later.
//  - Single read: f_stb with f_adr=16'h0010, RAM[0x10]=16'hBEEF.
//    -> m_adr=0x0010; f_ack with f_dti=16'hBEEF; g_ack stays 0.
//  - Contention: f and g both request at the same edge.
//    -> RR_EN: f, then g, then f... with 1 IDLE cycle between grants.
//    -> Without RR_EN: g is granted first every time.
//  - Write passthrough: g_wre=1, g_adr=16'h0200, g_dto=16'h1234.
//    -> m_wre=1, m_dto=16'h1234; a later f read of 0x0200 returns 16'h1234.
//  - Timeout: memory never acks, TMO=15.
//    -> g_err pulses exactly 16 cycles after m_stb rose; g_ack never asserts; the state is IDLE afterwards.
//  - Reset mid-grant: assert rst while in GNT_G with m_stb=1.
//    -> m_stb=0 in the same cycle; no spurious ack or err after release.

Source files
------------

// File: rtl/dcpu16_arb_pkg.sv
// Shared definitions for the DCPU16 memory-bus arbiter: state encoding,
// default watchdog limit and watchdog counter width.
package dcpu16_arb_pkg;

  // Arbiter state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_F = 2'd1;
  localparam logic [1:0] ST_GNT_G = 2'd2;

  // Default watchdog limit: grant cycles without m_ack before error termination
  localparam int TMO_DEFAULT = 15;

  // Watchdog counter width; limits TMO to 1..255
  localparam int WDT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_GNT_F = ST_GNT_F,
    S_GNT_G = ST_GNT_G
  } arb_state_e;

  // Round-robin choice on contention: serve the port that was not served last
  function automatic logic rr_pick_g(input logic last_g);
    return ~last_g;
  endfunction

endpackage

// File: rtl/dcpu16_arb_wdt.sv
// Watchdog for the memory-bus arbiter: a clear/enable cycle counter whose
// expiry output is high while the count equals the configured limit.
module dcpu16_arb_wdt
  import dcpu16_arb_pkg::*;
#(
  parameter int TMO = TMO_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic exp
);

  logic [WDT_W-1:0] cnt_q;

  // Count enabled cycles; clear wins over enable; saturate rather than wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {WDT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign exp = (cnt_q == WDT_W'(TMO));

endmodule

// File: rtl/dcpu16_mbus_arb.sv
// DCPU16 memory-bus arbiter: shares one single-port Wishbone-style memory
// between the fetch (f) and data (g) buses, one grant at a time, with a
// watchdog that turns an unanswered access into an error-terminated cycle.
//
// Configuration macro DCPU16_ARB_RR_EN:
//   defined   - round-robin on contention (f wins the first contention)
//   undefined - fixed priority, g always wins contention
//
// Handshake: a port raises x_stb and holds it (with adr/wre/dto stable)
// until x_ack or x_err is seen high for one cycle; the cycle ends at that
// clock edge. Every grant is followed by exactly one IDLE cycle.
//
// dbg_state exposes the FSM state (ST_* encoding from the package).
module dcpu16_mbus_arb
  import dcpu16_arb_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  // fetch bus
  input  logic [AW-1:0] f_adr,
  input  logic          f_stb,
  input  logic          f_wre,
  input  logic [DW-1:0] f_dto,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  output logic          f_err,
  // data bus
  input  logic [AW-1:0] g_adr,
  input  logic          g_stb,
  input  logic          g_wre,
  input  logic [DW-1:0] g_dto,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  output logic          g_err,
  // memory
  output logic [AW-1:0] m_adr,
  output logic          m_stb,
  output logic          m_wre,
  output logic [DW-1:0] m_dto,
  input  logic [DW-1:0] m_dti,
  input  logic          m_ack,
  // debug
  output logic [1:0]    dbg_state
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic gnt_f;
  logic gnt_g;
  logic pick_g;
  logic wdt_clr;
  logic wdt_en;
  logic wdt_exp;

  assign gnt_f = (state_q == S_GNT_F);
  assign gnt_g = (state_q == S_GNT_G);

  // ---------------------------------------------------------------------
  // Contention policy
  // ---------------------------------------------------------------------
`ifdef DCPU16_ARB_RR_EN
  logic last_g_q;

  // Remember which port was granted last; reset value lets f win first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_g_q <= 1'b1;
    end else if ((state_q == S_IDLE) && (state_d == S_GNT_G)) begin
      last_g_q <= 1'b1;
    end else if ((state_q == S_IDLE) && (state_d == S_GNT_F)) begin
      last_g_q <= 1'b0;
    end
  end

  assign pick_g = rr_pick_g(last_g_q);
`else
  // Fixed priority: g wins every contention; f may starve under g traffic
  assign pick_g = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register; reset forces IDLE immediately so m_stb drops at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: grant from IDLE, return to IDLE on ack, expiry or dropped stb
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (f_stb && g_stb) begin
          state_d = pick_g ? S_GNT_G : S_GNT_F;
        end else if (f_stb) begin
          state_d = S_GNT_F;
        end else if (g_stb) begin
          state_d = S_GNT_G;
        end
      end
      S_GNT_F: begin
        if (!f_stb || m_ack || wdt_exp) begin
          state_d = S_IDLE;
        end
      end
      S_GNT_G: begin
        if (!g_stb || m_ack || wdt_exp) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Watchdog: counts grant cycles, cleared on every return to IDLE
  // ---------------------------------------------------------------------
  assign wdt_clr = (state_d == S_IDLE);
  assign wdt_en  = (state_q != S_IDLE);

  dcpu16_arb_wdt #(
    .TMO (TMO)
  ) u_wdt (
    .clk (clk),
    .rst (rst),
    .clr (wdt_clr),
    .en  (wdt_en),
    .exp (wdt_exp)
  );

  // ---------------------------------------------------------------------
  // Memory-side mux and port responses
  // ---------------------------------------------------------------------

  // Route the granted port to the memory; bus is all-zero without a grant
  always_comb begin
    m_adr = '0;
    m_stb = 1'b0;
    m_wre = 1'b0;
    m_dto = '0;
    case (state_q)
      S_GNT_F: begin
        m_adr = f_adr;
        m_stb = f_stb;
        m_wre = f_wre;
        m_dto = f_dto;
      end
      S_GNT_G: begin
        m_adr = g_adr;
        m_stb = g_stb;
        m_wre = g_wre;
        m_dto = g_dto;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; only the granted port sees ack or err.
  // An ack arriving in the expiry cycle wins, so err is masked by m_ack.
  assign f_dti = m_dti;
  assign g_dti = m_dti;
  assign f_ack = m_ack & gnt_f;
  assign g_ack = m_ack & gnt_g;
  assign f_err = wdt_exp & ~m_ack & gnt_f;
  assign g_err = wdt_exp & ~m_ack & gnt_g;

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// Testbench for dcpu16_mbus_arb: drivers on the f and g buses, a
// behavioural memory, a reference model of arbitration order and memory
// contents, and a negedge monitor that pops expected responses.
module tb_dcpu16_mbus_arb;
  import dcpu16_arb_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 15;
  localparam int EW  = 18;  // {is_read, err, data}
`ifdef DCPU16_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] f_adr = '0, g_adr = '0, m_adr;
  logic          f_stb = 1'b0, f_wre = 1'b0, g_stb = 1'b0, g_wre = 1'b0;
  logic [DW-1:0] f_dto = '0, g_dto = '0, f_dti, g_dti, m_dto;
  logic [DW-1:0] m_dti = '0;
  logic          f_ack, f_err, g_ack, g_err, m_stb, m_wre;
  logic          m_ack = 1'b0;
  logic [1:0]    dbg_state;

  dcpu16_mbus_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto),
    .f_dti(f_dti), .f_ack(f_ack), .f_err(f_err),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto),
    .g_dti(g_dti), .g_ack(g_ack), .g_err(g_err),
    .m_adr(m_adr), .m_stb(m_stb), .m_wre(m_wre), .m_dto(m_dto),
    .m_dti(m_dti), .m_ack(m_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] ram     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [EW-1:0] f_exp_q[$];
  logic [EW-1:0] g_exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Expected grant after an IDLE cycle with the given requests pending
  function automatic logic [1:0] exp_winner(input logic fr, input logic gr, input logic lg);
    if (fr && gr) return (RR && lg) ? ST_GNT_F : ST_GNT_G;
    return fr ? ST_GNT_F : ST_GNT_G;
  endfunction

  // ---------------- behavioural memory ----------------
  int mem_lat_fix = -1;
  bit mem_no_ack  = 1'b0;
  int mem_cnt = 0;
  int mem_lat = 0;

  // Ack after a random (or forced) number of strobe cycles
  always @(posedge clk) begin
    #2;
    if (!rst && m_stb) begin
      if (mem_cnt == 0) mem_lat = (mem_lat_fix >= 0) ? mem_lat_fix : int'($urandom_range(0, 4));
      if (!mem_no_ack && mem_cnt == mem_lat) begin
        m_ack = 1'b1;
        if (m_wre) begin
          ram[m_adr] = m_dto;
          m_dti = 16'($urandom);
        end else begin
          m_dti = ram[m_adr];
        end
      end else begin
        m_ack = 1'b0;
        m_dti = 16'($urandom);
      end
      mem_cnt++;
    end else begin
      m_ack = 1'b0;
      mem_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  logic       last_g_m = 1'b1;
  logic [1:0] prev_state = ST_IDLE;
  logic       prev_f = 1'b0, prev_g = 1'b0, prev_end = 1'b0;
  int         stb_cyc = 0;
  logic [1:0] mon_cur, mon_w;
  logic [EW-1:0] mon_e;

  // Compare grants, bus routing and responses against the model
  always @(negedge clk) begin
    if (rst) begin
      last_g_m = 1'b1; prev_state = ST_IDLE; prev_f = 1'b0; prev_g = 1'b0;
      prev_end = 1'b0; stb_cyc = 0;
    end else begin
      mon_cur = dbg_state;
      if (prev_end) check("turnaround_idle", mon_cur, ST_IDLE);
      if (prev_state == ST_IDLE && (prev_f || prev_g)) begin
        mon_w = exp_winner(prev_f, prev_g, last_g_m);
        check("grant", mon_cur, mon_w);
        last_g_m = (mon_w == ST_GNT_G);
        stb_cyc = 0;
      end
      if (mon_cur == ST_GNT_F)
        check("mux_f", {m_stb, m_wre, m_adr, m_dto}, {f_stb, f_wre, f_adr, f_dto});
      else if (mon_cur == ST_GNT_G)
        check("mux_g", {m_stb, m_wre, m_adr, m_dto}, {g_stb, g_wre, g_adr, g_dto});
      else
        check("idle_bus", {m_stb, m_wre, m_adr, m_dto, f_ack, g_ack, f_err, g_err}, 64'd0);
      if (mon_cur != ST_IDLE && m_stb) stb_cyc++;

      if (f_ack || f_err) begin
        check("f_owner", mon_cur, ST_GNT_F);
        check("f_ack_err_excl", f_ack & f_err, 1'b0);
        if (f_exp_q.size() == 0) fail("f_unexpected_response");
        else begin
          mon_e = f_exp_q.pop_front();
          check("f_err", f_err, mon_e[16]);
          if (mon_e[17] && !mon_e[16]) check("f_rdata", f_dti, mon_e[15:0]);
          if (f_err) check("f_tmo_cycles", stb_cyc, TMO + 1);
        end
      end
      if (g_ack || g_err) begin
        check("g_owner", mon_cur, ST_GNT_G);
        check("g_ack_err_excl", g_ack & g_err, 1'b0);
        if (g_exp_q.size() == 0) fail("g_unexpected_response");
        else begin
          mon_e = g_exp_q.pop_front();
          check("g_err", g_err, mon_e[16]);
          if (mon_e[17] && !mon_e[16]) check("g_rdata", g_dti, mon_e[15:0]);
          if (g_err) check("g_tmo_cycles", stb_cyc, TMO + 1);
        end
      end
      prev_end   = f_ack | f_err | g_ack | g_err;
      prev_state = mon_cur;
      prev_f     = f_stb;
      prev_g     = g_stb;
    end
  end

  // ---------------- driver ----------------
  // One transaction on port p (0 = f, 1 = g); expectation pushed at issue
  task automatic drive(input int p, input logic [AW-1:0] adr, input logic wre,
                       input logic [DW-1:0] dto, input logic exp_err);
    logic [EW-1:0] e;
    bit done;
    e = {~wre, exp_err, (wre ? dto : ref_mem[adr])};
    if (wre && !exp_err) ref_mem[adr] = dto;
    @(posedge clk); #1;
    if (p == 0) begin
      f_adr = adr; f_wre = wre; f_dto = dto; f_stb = 1'b1; f_exp_q.push_back(e);
    end else begin
      g_adr = adr; g_wre = wre; g_dto = dto; g_stb = 1'b1; g_exp_q.push_back(e);
    end
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (p == 0) ? (f_ack | f_err) : (g_ack | g_err);
    end
    if (!done) fail(p == 0 ? "f_drive_timeout" : "g_drive_timeout");
    @(posedge clk); #1;
    if (p == 0) begin
      f_stb = 1'b0; f_wre = 1'b0; f_adr = 16'($urandom); f_dto = 16'($urandom);
    end else begin
      g_stb = 1'b0; g_wre = 1'b0; g_adr = 16'($urandom); g_dto = 16'($urandom);
    end
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  // ---------------- test sequence ----------------
  logic any_flag;
  logic [DW-1:0] v;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      v = 16'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    ram[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;

    // Reset held with both requests pending
    rst = 1'b1; f_stb = 1'b1; g_stb = 1'b1;
    f_adr = 16'h0010; g_adr = 16'h0020; mem_no_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bus", {m_stb, f_ack, g_ack, f_err, g_err}, 64'd0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("release_idle_cycle", m_stb, 1'b0);
    @(negedge clk);
    check("release_first_grant", m_stb, 1'b1);

    // Reset mid-grant: m_stb drops without a clock edge
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midgrant_mstb", m_stb, 1'b0);
    check("midgrant_flags", {f_ack, g_ack, f_err, g_err}, 64'd0);
    f_stb = 1'b0; g_stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    mem_no_ack = 1'b0;
    any_flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_flag = any_flag | f_ack | g_ack | f_err | g_err;
    end
    check("post_reset_quiet", any_flag, 1'b0);

    // Single read, write passthrough and read-back across ports
    drive(0, 16'h0010, 1'b0, 16'h0000, 1'b0);
    drive(1, 16'h0200, 1'b1, 16'h1234, 1'b0);
    drive(0, 16'h0200, 1'b0, 16'h0000, 1'b0);

    // Contention: both raise stb at the same edge
    repeat (6) begin
      fork
        drive(0, 16'h0400 + 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
        drive(1, 16'h0500 + 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      join
    end

    // Timeouts on each port, then ack landing exactly on the expiry cycle
    mem_no_ack = 1'b1;
    drive(1, 16'h0300, 1'b0, 16'h0000, 1'b1);
    drive(0, 16'h0301, 1'b1, 16'h5555, 1'b1);
    mem_no_ack = 1'b0;
    mem_lat_fix = TMO;
    drive(1, 16'h0302, 1'b0, 16'h0000, 1'b0);
    mem_lat_fix = TMO - 1;
    drive(0, 16'h0303, 1'b0, 16'h0000, 1'b0);
    mem_lat_fix = -1;

    // Granted stb dropped before any ack
    mem_no_ack = 1'b1;
    @(posedge clk); #1 g_adr = 16'h0600; g_wre = 1'b0; g_stb = 1'b1;
    repeat (3) @(negedge clk);
    check("viol_granted", dbg_state, ST_GNT_G);
    @(posedge clk); #1 g_stb = 1'b0;
    @(negedge clk);
    check("viol_mstb_low", m_stb, 1'b0);
    @(negedge clk);
    check("viol_back_idle", dbg_state, ST_IDLE);
    check("viol_no_resp", {f_ack, g_ack, f_err, g_err}, 64'd0);
    mem_no_ack = 1'b0;

    // Randomized concurrent traffic, disjoint address regions per port
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        drive(0, 16'h0400 + 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        drive(1, 16'h0500 + 16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      end
    join

    repeat (4) @(negedge clk);
    check("f_queue_drained", f_exp_q.size(), 64'd0);
    check("g_queue_drained", g_exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
